// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMMIT,
    S_EXC
  } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Owns HI/LO and arbitrates between the external divider and multiplier:
// latches a request, launches one unit, waits (bounded) for its result and
// commits it to HI/LO. Divide-by-zero is reported without launching anything.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W     = muldiv_pkg::DATA_W,
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic              div_zero_exc,
  output logic              timeout_err,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic              mult_start,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              unit_done;
  logic [CNT_W-1:0]  cnt_inc;

  // State, counter, operand and HI/LO registers; reset abandons any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state logic; only the launched unit's done is looked at, and a done
  // arriving on the last allowed WAIT cycle still beats the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    timeout_err = 1'b0;
    unit_done   = is_div_q ? div_done : mult_done;
    cnt_inc     = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (op_valid && (op_code == OP_MULT || op_code == OP_DIV)) begin
          is_div_d = (op_code == OP_DIV);
          opa_d    = rs_val;
          opb_d    = rt_val;
          if (op_code == OP_DIV && rt_val == '0) state_d = S_EXC;
          else                                   state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (unit_done) begin
          res_hi_d = is_div_q ? div_hi : mult_hi;
          res_lo_d = is_div_q ? div_lo : mult_lo;
          state_d  = S_COMMIT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MAX_CNT) begin
            timeout_err = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        hi_d    = res_hi_q;
        lo_d    = res_lo_q;
        state_d = S_IDLE;
      end
      S_EXC: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_COMMIT);
  assign div_zero_exc = (state_q == S_EXC);
  assign div_start    = (state_q == S_LAUNCH) &&  is_div_q;
  assign mult_start   = (state_q == S_LAUNCH) && !is_div_q;
  assign div_a        = opa_q;
  assign div_b        = opb_q;
  assign mult_a       = opa_q;
  assign mult_b       = opb_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: the bench itself plays the divider and
// multiplier, returning hand-computed results after a chosen latency.
module tb_muldiv_seq;

  localparam int W       = 32;
  localparam int MAXC    = 40;
  localparam int LOOPMAX = 45;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    op_code = 2'b00;
  logic [W-1:0]  rs_val = '0, rt_val = '0;
  logic          busy, done, div_zero_exc, timeout_err;
  logic          div_start, mult_start;
  logic [W-1:0]  div_a, div_b, mult_a, mult_b;
  logic          div_done = 1'b0, mult_done = 1'b0;
  logic [W-1:0]  div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string      name;
    logic [1:0] code;
    logic [W-1:0] a, b;
    int         lat;       // WAIT cycle in which the unit reports done; 0 = never
    logic [W-1:0] uhi, ulo;
    bit         spur;      // spurious div_done in the first WAIT cycle
    logic [W-1:0] ehi, elo;
  } vec_t;

  vec_t vecs[6];

  muldiv_seq #(.DATA_W(W), .MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .timeout_err(timeout_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, act as the selected unit, and check the whole exchange.
  task automatic applyStimulus(input vec_t v);
    bit isDiv, isExc, waitErr, startErr;
    logic [W-1:0] priorHi, priorLo;
    int k;
    isDiv   = (v.code == 2'b10);
    isExc   = isDiv && (v.b == '0);
    priorHi = hi;
    priorLo = lo;
    @(negedge clk);
    op_valid = 1'b1; op_code = v.code; rs_val = v.a; rt_val = v.b;
    #1 checkOutput({v.name, " busy at accept"}, W'(busy), W'(0));
    @(negedge clk);
    op_valid = 1'b0;
    if (isExc) begin
      checkOutput({v.name, " exc pulse"}, W'(div_zero_exc), W'(1));
      checkOutput({v.name, " no start"}, W'(div_start | mult_start), W'(0));
      checkOutput({v.name, " busy in exc"}, W'(busy), W'(1));
      @(negedge clk);
      checkOutput({v.name, " exc one cycle"}, W'(div_zero_exc), W'(0));
      checkOutput({v.name, " busy after exc"}, W'(busy), W'(0));
      checkOutput({v.name, " hi kept"}, hi, priorHi);
      checkOutput({v.name, " lo kept"}, lo, priorLo);
      return;
    end
    checkOutput({v.name, " div_start"}, W'(div_start), W'(isDiv));
    checkOutput({v.name, " mult_start"}, W'(mult_start), W'(!isDiv));
    checkOutput({v.name, " operand a"}, isDiv ? div_a : mult_a, v.a);
    checkOutput({v.name, " operand b"}, isDiv ? div_b : mult_b, v.b);
    waitErr  = 1'b0;
    startErr = 1'b0;
    for (k = 1; k <= LOOPMAX; k++) begin
      @(negedge clk);
      div_done = 1'b0; mult_done = 1'b0;
      if (v.spur && k == 1) begin
        div_done = 1'b1; div_hi = 32'hDEAD_BEEF; div_lo = 32'hBAD0_BAD0;
      end
      if (k == v.lat) begin
        if (isDiv) begin div_done = 1'b1; div_hi = v.uhi; div_lo = v.ulo; end
        else       begin mult_done = 1'b1; mult_hi = v.uhi; mult_lo = v.ulo; end
      end
      #1;
      if (timeout_err !== (v.lat == 0 && k == MAXC)) waitErr = 1'b1;
      if (done !== 1'b0 || busy !== 1'b1) waitErr = 1'b1;
      if (div_start !== 1'b0 || mult_start !== 1'b0) startErr = 1'b1;
      if (k == v.lat || (v.lat == 0 && k == MAXC)) break;
    end
    checkOutput({v.name, " wait phase"}, W'(waitErr), W'(0));
    checkOutput({v.name, " single start"}, W'(startErr), W'(0));
    checkOutput({v.name, " wait cycles"}, W'(k), W'(v.lat == 0 ? MAXC : v.lat));
    @(negedge clk);
    div_done = 1'b0; mult_done = 1'b0;
    if (v.lat == 0) begin
      checkOutput({v.name, " timeout one cycle"}, W'(timeout_err), W'(0));
      checkOutput({v.name, " busy after timeout"}, W'(busy), W'(0));
      checkOutput({v.name, " no done"}, W'(done), W'(0));
    end else begin
      checkOutput({v.name, " done pulse"}, W'(done), W'(1));
      checkOutput({v.name, " busy in commit"}, W'(busy), W'(1));
      @(negedge clk);
      checkOutput({v.name, " done one cycle"}, W'(done), W'(0));
      checkOutput({v.name, " busy after commit"}, W'(busy), W'(0));
    end
    checkOutput({v.name, " hi"}, hi, v.ehi);
    checkOutput({v.name, " lo"}, lo, v.elo);
  endtask

  // Main sequence: reset, vector table, then hand-written corner cases.
  initial begin
    vecs[0] = '{"div20/3",   2'b10, 32'd20, 32'd3, 33, 32'd2, 32'd6, 1'b0, 32'd2, 32'd6};
    vecs[1] = '{"div7/0",    2'b10, 32'd7,  32'd0, 0,  32'd0, 32'd0, 1'b0, 32'd2, 32'd6};
    vecs[2] = '{"multmax*2", 2'b01, 32'hFFFF_FFFF, 32'd2, 4, 32'd1, 32'hFFFF_FFFE, 1'b1,
                32'd1, 32'hFFFF_FFFE};
    vecs[3] = '{"div9/3 tmo", 2'b10, 32'd9, 32'd3, 0, 32'd0, 32'd0, 1'b0,
                32'd1, 32'hFFFF_FFFE};
    vecs[4] = '{"mult6*7",   2'b01, 32'd6,  32'd7, 1,  32'd0, 32'd42, 1'b0, 32'd0, 32'd42};
    vecs[5] = '{"div9/3 edge", 2'b10, 32'd9, 32'd3, MAXC, 32'd0, 32'd3, 1'b0, 32'd0, 32'd3};

    repeat (2) @(negedge clk);
    checkOutput("reset busy", W'(busy), W'(0));
    checkOutput("reset pulses", W'({done, div_zero_exc, timeout_err, div_start, mult_start}), W'(0));
    checkOutput("reset hi", hi, '0);
    checkOutput("reset lo", lo, '0);
    checkOutput("reset operands", div_a | div_b | mult_a | mult_b, '0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Invalid opcode is ignored.
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b11; rs_val = 32'd5; rt_val = 32'd5;
    @(negedge clk);
    op_valid = 1'b0; op_code = 2'b00;
    checkOutput("invalid op busy", W'(busy), W'(0));
    checkOutput("invalid op start", W'(div_start | mult_start), W'(0));

    // DIV held while a MULT is running; accepted only after the MULT commits.
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b01; rs_val = 32'd3; rt_val = 32'd5;
    @(negedge clk);
    op_code = 2'b10; rs_val = 32'd50; rt_val = 32'd5;
    checkOutput("b2b mult_start", W'({mult_start, div_start}), W'(2'b10));
    @(negedge clk);
    mult_done = 1'b1; mult_hi = 32'd0; mult_lo = 32'd15;
    @(negedge clk);
    mult_done = 1'b0;
    checkOutput("b2b mult done", W'({done, div_start}), W'(2'b10));
    @(negedge clk);
    checkOutput("b2b idle busy", W'(busy), W'(0));
    checkOutput("b2b mult lo", lo, 32'd15);
    @(negedge clk);
    op_valid = 1'b0;
    checkOutput("b2b div_start", W'({div_start, mult_start}), W'(2'b10));
    checkOutput("b2b div_a", div_a, 32'd50);
    @(negedge clk);
    div_done = 1'b1; div_hi = 32'd0; div_lo = 32'd10;
    @(negedge clk);
    div_done = 1'b0;
    checkOutput("b2b div done", W'(done), W'(1));
    @(negedge clk);
    checkOutput("b2b div done once", W'(done), W'(0));
    checkOutput("b2b div lo", lo, 32'd10);

    // Reset in the middle of a DIV; a late divider done must not commit.
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b10; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid reset busy", W'(busy), W'(0));
    checkOutput("mid reset hi", hi, '0);
    checkOutput("mid reset lo", lo, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    div_done = 1'b1; div_hi = 32'd2; div_lo = 32'd14;
    #1 checkOutput("late done no commit", W'(done), W'(0));
    @(negedge clk);
    div_done = 1'b0;
    checkOutput("late done busy", W'(busy), W'(0));
    checkOutput("late done lo", lo, '0);
    @(negedge clk);
    checkOutput("late done hi", hi, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
